blockram_arbiter: RTL and testbench

BLOCKRAM_ARBITER -- requirements
Module: blockram_arbiter

---
 rtl/blockram_arbiter.sv | 100 ++++++++++
 tb/tb_blockram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/blockram_arbiter.sv
// Two-requester arbiter in front of a single-port-per-direction block RAM.
// Define ARB_FIXED_PRIO_EN for fixed A-priority; default build is round-robin.
module blockram_arbiter (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       AValid,
  output logic       AReady,
  input  logic       AWrite,
  input  logic [9:0] AAddr,
  input  logic [7:0] AWData,
  output logic       ARValid,
  input  logic       BValid,
  output logic       BReady,
  input  logic       BWrite,
  input  logic [9:0] BAddr,
  input  logic [7:0] BWData,
  output logic       BRValid,
  output logic [7:0] RData,
  output logic       RamReadEnable,
  output logic [9:0] RamReadAddr,
  input  logic [7:0] RamReadData,
  output logic       RamWriteEnable,
  output logic [9:0] RamWriteAddr,
  output logic [7:0] RamWriteData
);

  logic       r_live;
  logic       r_tag1Valid;
  logic       r_tag1B;
  logic       w_pickA;
  logic       w_accept;
  logic       w_write;
  logic [9:0] w_addr;
  logic [7:0] w_data;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_pickA = 1'b1;
  end
`else
  logic r_lastGrantB;

  // Round-robin: on contention, the requester not granted last wins.
  always_comb begin
    w_pickA = !BValid || r_lastGrantB;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_lastGrantB <= 1'b1;
    end else if (w_accept) begin
      r_lastGrantB <= BReady;
    end
  end
`endif

  always_comb begin
    AReady   = r_live && AValid && w_pickA;
    BReady   = r_live && BValid && !AReady;
    w_accept = AReady || BReady;
    w_write  = BReady ? BWrite : AWrite;
    w_addr   = BReady ? BAddr  : AAddr;
    w_data   = BReady ? BWData : AWData;
  end

  assign RData = RamReadData;

  // r_live holds grants off for the first cycle after reset release.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_live         <= 1'b0;
      RamReadEnable  <= 1'b0;
      RamWriteEnable <= 1'b0;
      RamReadAddr    <= '0;
      RamWriteAddr   <= '0;
      RamWriteData   <= '0;
      r_tag1Valid    <= 1'b0;
      r_tag1B        <= 1'b0;
      ARValid        <= 1'b0;
      BRValid        <= 1'b0;
    end else begin
      r_live         <= 1'b1;
      RamReadEnable  <= w_accept && !w_write;
      RamWriteEnable <= w_accept && w_write;
      if (w_accept && !w_write) begin
        RamReadAddr <= w_addr;
      end
      if (w_accept && w_write) begin
        RamWriteAddr <= w_addr;
        RamWriteData <= w_data;
      end
      // Tag stage 1 tracks the issue cycle, stage 2 is the RValid pulse.
      r_tag1Valid <= w_accept && !w_write;
      r_tag1B     <= BReady;
      ARValid     <= r_tag1Valid && !r_tag1B;
      BRValid     <= r_tag1Valid && r_tag1B;
    end
  end

endmodule

// File: tb/tb_blockram_arbiter.sv
// Directed self-checking bench for blockram_arbiter with a behavioural block RAM.
module tb_blockram_arbiter;

  logic       Clk;
  logic       nReset;
  logic       AValid, AReady, AWrite, ARValid;
  logic [9:0] AAddr;
  logic [7:0] AWData;
  logic       BValid, BReady, BWrite, BRValid;
  logic [9:0] BAddr;
  logic [7:0] BWData;
  logic [7:0] RData;
  logic       RamReadEnable, RamWriteEnable;
  logic [9:0] RamReadAddr, RamWriteAddr;
  logic [7:0] RamReadData, RamWriteData;

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0] mem [0:1023];

  blockram_arbiter dut (
    .Clk(Clk), .nReset(nReset),
    .AValid(AValid), .AReady(AReady), .AWrite(AWrite), .AAddr(AAddr),
    .AWData(AWData), .ARValid(ARValid),
    .BValid(BValid), .BReady(BReady), .BWrite(BWrite), .BAddr(BAddr),
    .BWData(BWData), .BRValid(BRValid),
    .RData(RData),
    .RamReadEnable(RamReadEnable), .RamReadAddr(RamReadAddr),
    .RamReadData(RamReadData),
    .RamWriteEnable(RamWriteEnable), .RamWriteAddr(RamWriteAddr),
    .RamWriteData(RamWriteData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM with registered read output
  always @(posedge Clk) begin
    if (RamWriteEnable) mem[RamWriteAddr] <= RamWriteData;
    if (RamReadEnable)  RamReadData <= mem[RamReadAddr];
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) begin
      nPass++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic aw, input logic [9:0] aa, input logic [7:0] ad,
                               input logic bv, input logic bw, input logic [9:0] ba, input logic [7:0] bd);
    AValid = av; AWrite = aw; AAddr = aa; AWData = ad;
    BValid = bv; BWrite = bw; BAddr = ba; BWData = bd;
  endtask

  logic expA, expB;
  int   aGrants, bPulses;

  initial begin
    nReset = 1'b0;
    applyStimulus(1, 0, 10'h000, 8'h00, 1, 0, 10'h000, 8'h00);
    RamReadData = 8'h00;

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("rst_AReady", AReady, 0);
    checkOutput("rst_BReady", BReady, 0);
    checkOutput("rst_RamReadEnable", RamReadEnable, 0);
    checkOutput("rst_RamWriteEnable", RamWriteEnable, 0);
    checkOutput("rst_RValid", {ARValid, BRValid}, 0);
    checkOutput("rst_RamReadAddr", RamReadAddr, 0);
    checkOutput("rst_RamWriteAddr", RamWriteAddr, 0);
    checkOutput("rst_RamWriteData", RamWriteData, 0);
    @(posedge Clk); #1 nReset = 1'b1;
    @(negedge Clk);
    checkOutput("release_Ready", {AReady, BReady}, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Preload 0x155 = 0x5A via B write
    applyStimulus(0, 0, 0, 0, 1, 1, 10'h155, 8'h5A);
    @(negedge Clk); checkOutput("preload_BReady", BReady, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    checkOutput("preload_wen", {RamWriteEnable, RamReadEnable}, 2'b10);
    checkOutput("preload_waddr", RamWriteAddr, 10'h155);
    checkOutput("preload_wdata", RamWriteData, 8'h5A);
    tick(); @(negedge Clk);
    checkOutput("preload_wen_drop", RamWriteEnable, 0);
    tick();

    // Single A read of 0x155
    applyStimulus(1, 0, 10'h155, 8'h00, 0, 0, 0, 0);
    @(negedge Clk); checkOutput("rd_AReady", AReady, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    checkOutput("rd_ren", {RamReadEnable, RamWriteEnable}, 2'b10);
    checkOutput("rd_raddr", RamReadAddr, 10'h155);
    checkOutput("rd_RValid_early", ARValid, 0);
    tick(); @(negedge Clk);
    checkOutput("rd_ARValid", ARValid, 1);
    checkOutput("rd_BRValid", BRValid, 0);
    checkOutput("rd_RData", RData, 8'h5A);
    checkOutput("rd_ren_drop", RamReadEnable, 0);
    checkOutput("rd_raddr_hold", RamReadAddr, 10'h155);
    tick(); @(negedge Clk);
    checkOutput("rd_ARValid_drop", ARValid, 0);

    // B writes 0xC3 to 0x3FF, A reads it the next cycle
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 10'h3FF, 8'hC3);
    @(negedge Clk); checkOutput("wr_BReady", BReady, 1);
    tick(); applyStimulus(1, 0, 10'h3FF, 8'h00, 0, 0, 0, 0);
    @(negedge Clk); checkOutput("wr_rd_AReady", AReady, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); @(negedge Clk);
    checkOutput("wr_rd_ARValid", ARValid, 1);
    checkOutput("wr_rd_RData", RData, 8'hC3);

    // B write 0x200 = 0x77 leaves LastGrant on B
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 10'h200, 8'h77);
    @(negedge Clk); checkOutput("wr2_BReady", BReady, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Contention: both valid for 4 cycles
    applyStimulus(1, 0, 10'h155, 8'h00, 1, 0, 10'h200, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
`ifdef ARB_FIXED_PRIO_EN
      expA = 1'b1;
`else
      expA = (i % 2) == 0;
`endif
      if (i < 4) begin
        checkOutput($sformatf("rr_ready_%0d", i), {AReady, BReady}, {expA, ~expA});
      end
      if (i >= 2) begin
`ifdef ARB_FIXED_PRIO_EN
        expB = 1'b0;
`else
        expB = (i % 2) == 1;
`endif
        checkOutput($sformatf("rr_rvalid_%0d", i), {ARValid, BRValid}, {~expB, expB});
        checkOutput($sformatf("rr_rdata_%0d", i), RData, expB ? 8'h77 : 8'h5A);
      end
      tick();
      if (i == 3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    end
    repeat (2) tick();

    // Reset in the cycle after an A read is accepted
    applyStimulus(1, 0, 10'h155, 8'h00, 0, 0, 0, 0);
    @(negedge Clk); checkOutput("mid_AReady", AReady, 1);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nReset = 1'b0;
    @(negedge Clk);
    checkOutput("mid_outputs", {RamReadEnable, RamWriteEnable, ARValid, BRValid}, 0);
    checkOutput("mid_raddr", RamReadAddr, 0);
    checkOutput("mid_waddr", RamWriteAddr, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge Clk);
      checkOutput($sformatf("mid_no_rvalid_%0d", i), {ARValid, BRValid}, 0);
    end
    @(posedge Clk); #1 nReset = 1'b1;
    applyStimulus(1, 0, 10'h155, 8'h00, 1, 0, 10'h200, 8'h00);
    @(negedge Clk); checkOutput("mid_release_ready", {AReady, BReady}, 0);
    checkOutput("mid_release_rvalid", {ARValid, BRValid}, 0);
    tick(); @(negedge Clk);
    checkOutput("mid_first_grant", {AReady, BReady}, 2'b10);
    tick();

    // Six more cycles of continuous contention
    aGrants = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
`ifdef ARB_FIXED_PRIO_EN
      checkOutput($sformatf("fix_BReady_%0d", i), BReady, 0);
`else
      checkOutput($sformatf("rr6_BReady_%0d", i), BReady, (i % 2) == 0);
`endif
      if (AReady) aGrants++;
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_FIXED_PRIO_EN
    checkOutput("fix_AGrants", aGrants, 6);
`else
    checkOutput("rr6_AGrants", aGrants, 3);
`endif
    repeat (4) tick();

    // Throughput: alternating A writes and B reads of 10 addresses
    bPulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 20 && (i % 2) == 0)
        applyStimulus(1, 1, 10'(16 + i / 2), 8'(8'hA0 + i / 2), 0, 0, 0, 0);
      else if (i < 20)
        applyStimulus(0, 0, 0, 0, 1, 0, 10'(16 + i / 2), 8'h00);
      else
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      if (i < 20)
        checkOutput($sformatf("tp_ready_%0d", i), {AReady, BReady}, (i % 2) == 0 ? 2'b10 : 2'b01);
      if (i >= 2) begin
        checkOutput($sformatf("tp_rvalid_%0d", i), {ARValid, BRValid},
                    (i % 2 == 1 && i < 22) ? 2'b01 : 2'b00);
        if (i % 2 == 1 && i < 22)
          checkOutput($sformatf("tp_rdata_%0d", i), RData, 8'(8'hA0 + (i - 3) / 2));
      end
      if (BRValid) bPulses++;
      tick();
    end
    checkOutput("tp_pulse_count", bPulses, 10);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
